// File: rtl/minisrc_ctrl_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: opcodes, ALU
// operation codes, sequencer steps and IR field positions.
package minisrc_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;
    localparam int C_MSB   = 18;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_ROR  = 4'd4,
        ALU_ROL  = 4'd5,
        ALU_SHR  = 4'd6,
        ALU_SHRA = 4'd7,
        ALU_SHL  = 4'd8
    } alu_op_t;

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd8
    } step_t;

    typedef enum logic [1:0] {
        SEL_RA = 2'd0,
        SEL_RB = 2'd1,
        SEL_RC = 2'd2
    } reg_sel_t;

    // Address arithmetic (ld/ldi/st/addi) and anything unlisted falls back to ADD.
    function automatic alu_op_t alu_for_opcode(input logic [4:0] opc);
        alu_op_t op;
        op = ALU_ADD;
        case (opc)
            OP_SUB:          op = ALU_SUB;
            OP_AND, OP_ANDI: op = ALU_AND;
            OP_OR, OP_ORI:   op = ALU_OR;
            OP_ROR:          op = ALU_ROR;
            OP_ROL:          op = ALU_ROL;
            OP_SHR:          op = ALU_SHR;
            OP_SHRA:         op = ALU_SHRA;
            OP_SHL:          op = ALU_SHL;
            default:         op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// One-hot general-purpose register select: picks Ra, Rb or Rc and decodes it
// to a 16-bit strobe vector, all zero when not enabled.
module reg_select_decoder
    import minisrc_ctrl_pkg::*;
(
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rc,
    input  reg_sel_t    sel,
    input  logic        en,
    output logic [15:0] onehot
);

    logic [3:0] idx;

    always_comb begin
        idx = ra;
        case (sel)
            SEL_RA:  idx = ra;
            SEL_RB:  idx = rb;
            SEL_RC:  idx = rc;
            default: idx = ra;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_onehot
            assign onehot[gi] = en && (idx == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch in T0-T2, execute in T3-T7, with
// Moore strobes from the step register and Mealy mdr_in during memory waits.
module control_sequencer
    import minisrc_ctrl_pkg::*;
#(
    parameter int ADDR_MODE_ZERO = 1
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        pc_out,
    output logic        inc_pc,
    output logic        pc_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        zlo_out,
    output logic        c_out,
    output logic        ba_out,
    output logic        read,
    output logic        write,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic [3:0]  alu_op,
    output logic [31:0] c_sext,
    output logic [3:0]  step,
    output logic        halted,
    output logic        illegal
);

    step_t    state_reg, state_next;
    logic     illegal_reg, illegal_next;
    alu_op_t  alu_sel;
    logic     in_en, out_en;
    reg_sel_t in_sel, out_sel;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_ld, is_ldi, is_st, is_rr, is_imm, is_nop, is_halt;
    logic       is_mem, uses_c, legal, base_zero;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign ra     = ir[RA_MSB:RA_LSB];
    assign rb     = ir[RB_MSB:RB_LSB];
    assign rc     = ir[RC_MSB:RC_LSB];
    assign c_sext = {{(31 - C_MSB){ir[C_MSB]}}, ir[C_MSB:0]};

    assign is_ld   = (opcode == OP_LD);
    assign is_ldi  = (opcode == OP_LDI);
    assign is_st   = (opcode == OP_ST);
    assign is_rr   = (opcode >= OP_ADD) && (opcode <= OP_SHL);
    assign is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);
    assign is_mem  = is_ld || is_st;
    assign uses_c  = is_mem || is_ldi || is_imm;
    assign legal   = is_mem || is_ldi || is_rr || is_imm || is_nop || is_halt;
    // R0 as a base register reads as zero through the BA path.
    assign base_zero = (ADDR_MODE_ZERO != 0) && (rb == 4'd0) && (is_mem || is_ldi);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg   <= T0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        illegal_next = illegal_reg;
        pc_out       = 1'b0;
        inc_pc       = 1'b0;
        mar_in       = 1'b0;
        mdr_in       = 1'b0;
        mdr_out      = 1'b0;
        ir_in        = 1'b0;
        y_in         = 1'b0;
        z_in         = 1'b0;
        zlo_out      = 1'b0;
        c_out        = 1'b0;
        ba_out       = 1'b0;
        read         = 1'b0;
        write        = 1'b0;
        alu_sel      = ALU_ADD;
        in_en        = 1'b0;
        in_sel       = SEL_RA;
        out_en       = 1'b0;
        out_sel      = SEL_RB;

        case (state_reg)
            T0: begin
                if (run) begin
                    pc_out     = 1'b1;
                    mar_in     = 1'b1;
                    inc_pc     = 1'b1;
                    state_next = T1;
                end
            end
            T1: begin
                read   = 1'b1;
                mdr_in = mem_ready;
                if (mem_ready) state_next = T2;
            end
            T2: begin
                mdr_out    = 1'b1;
                ir_in      = 1'b1;
                state_next = T3;
            end
            T3: begin
                if (is_nop) begin
                    state_next = T0;
                end else if (is_halt) begin
                    state_next = HALT;
                end else if (!legal) begin
                    state_next   = HALT;
                    illegal_next = 1'b1;
                end else begin
                    y_in = 1'b1;
                    if (base_zero) begin
                        ba_out = 1'b1;
                    end else begin
                        out_en  = 1'b1;
                        out_sel = SEL_RB;
                    end
                    state_next = T4;
                end
            end
            T4: begin
                z_in    = 1'b1;
                alu_sel = alu_for_opcode(opcode);
                if (uses_c) begin
                    c_out = 1'b1;
                end else begin
                    out_en  = 1'b1;
                    out_sel = SEL_RC;
                end
                state_next = T5;
            end
            T5: begin
                zlo_out = 1'b1;
                if (is_mem) begin
                    mar_in     = 1'b1;
                    state_next = T6;
                end else begin
                    in_en      = 1'b1;
                    in_sel     = SEL_RA;
                    state_next = T0;
                end
            end
            T6: begin
                if (is_ld) begin
                    read   = 1'b1;
                    mdr_in = mem_ready;
                    if (mem_ready) state_next = T7;
                end else begin
                    out_en     = 1'b1;
                    out_sel    = SEL_RA;
                    mdr_in     = 1'b1;
                    state_next = T7;
                end
            end
            T7: begin
                if (is_ld) begin
                    mdr_out    = 1'b1;
                    in_en      = 1'b1;
                    in_sel     = SEL_RA;
                    state_next = T0;
                end else begin
                    write = 1'b1;
                    if (mem_ready) state_next = T0;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = T0;
            end
        endcase
    end

    reg_select_decoder u_in_dec (
        .ra     (ra),
        .rb     (rb),
        .rc     (rc),
        .sel    (in_sel),
        .en     (in_en),
        .onehot (reg_in)
    );

    reg_select_decoder u_out_dec (
        .ra     (ra),
        .rb     (rb),
        .rc     (rc),
        .sel    (out_sel),
        .en     (out_en),
        .onehot (reg_out)
    );

    assign pc_in   = 1'b0;
    assign alu_op  = alu_sel;
    assign step    = state_reg;
    assign halted  = (state_reg == HALT);
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each instruction is walked cycle by
// cycle against hand-written expected strobe tables.
module tb_control_sequencer;

    logic        clock;
    logic        clear_n;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic        pc_out, inc_pc, pc_in, mar_in, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlo_out, c_out, ba_out, read, write;
    logic [15:0] reg_in, reg_out;
    logic [3:0]  alu_op;
    logic [31:0] c_sext;
    logic [3:0]  step;
    logic        halted, illegal;

    int checks   = 0;
    int failures = 0;

    control_sequencer #(.ADDR_MODE_ZERO(1)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .run       (run),
        .mem_ready (mem_ready),
        .ir        (ir),
        .pc_out    (pc_out),
        .inc_pc    (inc_pc),
        .pc_in     (pc_in),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .ir_in     (ir_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .zlo_out   (zlo_out),
        .c_out     (c_out),
        .ba_out    (ba_out),
        .read      (read),
        .write     (write),
        .reg_in    (reg_in),
        .reg_out   (reg_out),
        .alu_op    (alu_op),
        .c_sext    (c_sext),
        .step      (step),
        .halted    (halted),
        .illegal   (illegal)
    );

    localparam logic [13:0] M_PC_OUT  = 14'h0001;
    localparam logic [13:0] M_INC_PC  = 14'h0002;
    localparam logic [13:0] M_MAR_IN  = 14'h0008;
    localparam logic [13:0] M_MDR_IN  = 14'h0010;
    localparam logic [13:0] M_MDR_OUT = 14'h0020;
    localparam logic [13:0] M_IR_IN   = 14'h0040;
    localparam logic [13:0] M_Y_IN    = 14'h0080;
    localparam logic [13:0] M_Z_IN    = 14'h0100;
    localparam logic [13:0] M_ZLO_OUT = 14'h0200;
    localparam logic [13:0] M_C_OUT   = 14'h0400;
    localparam logic [13:0] M_BA_OUT  = 14'h0800;
    localparam logic [13:0] M_READ    = 14'h1000;
    localparam logic [13:0] M_WRITE   = 14'h2000;

    logic [13:0] strobes;
    logic [53:0] obs;
    assign strobes = {write, read, ba_out, c_out, zlo_out, z_in, y_in, ir_in,
                      mdr_out, mdr_in, mar_in, pc_in, inc_pc, pc_out};
    assign obs = {step, strobes, reg_in, reg_out, alu_op};

    function automatic logic [53:0] mk(input logic [3:0] s, input logic [13:0] st,
                                       input logic [15:0] ri, input logic [15:0] ro,
                                       input logic [3:0] op);
        return {s, st, ri, ro, op};
    endfunction

    logic [53:0] f0, f1, f2, idle0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic do_reset();
        clear_n = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'h0;
        @(negedge clock);
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_n = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'h0;
        #1;
        checks++;
        if (obs !== mk(4'd0, 14'h0, 16'h0, 16'h0, 4'd0)) begin
            failures++; $display("FAIL reset_outputs: got %h required %h", obs, mk(4'd0, 14'h0, 16'h0, 16'h0, 4'd0));
        end
        checks++;
        if ({halted, illegal} !== 2'b00) begin
            failures++; $display("FAIL reset_flags: got %b required 00", {halted, illegal});
        end
        @(negedge clock);
        clear_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock); #1;
            checks++;
            if (obs !== idle0) begin
                failures++; $display("FAIL reset_idle_c%0d: got %h required %h", k, obs, idle0);
            end
        end
    endtask

    task automatic test_add();
        logic [53:0] exp [0:6];
        do_reset();
        ir = 32'h18918000;
        exp = '{f0, f1, f2,
                mk(4'd3, M_Y_IN, 16'h0, 16'h0004, 4'd0),
                mk(4'd4, M_Z_IN, 16'h0, 16'h0008, 4'd0),
                mk(4'd5, M_ZLO_OUT, 16'h0002, 16'h0, 4'd0),
                idle0};
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            run = (k == 0); mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== exp[k]) begin
                failures++; $display("FAIL add_c%0d: got %h required %h", k, obs, exp[k]);
            end
        end
    endtask

    task automatic test_addi();
        logic [53:0] exp [0:6];
        do_reset();
        ir = 32'h6097FFFF;
        exp = '{f0, f1, f2,
                mk(4'd3, M_Y_IN, 16'h0, 16'h0004, 4'd0),
                mk(4'd4, M_Z_IN | M_C_OUT, 16'h0, 16'h0, 4'd0),
                mk(4'd5, M_ZLO_OUT, 16'h0002, 16'h0, 4'd0),
                idle0};
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            run = (k == 0); mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== exp[k]) begin
                failures++; $display("FAIL addi_c%0d: got %h required %h", k, obs, exp[k]);
            end
            if (k == 4) begin
                checks++;
                if (c_sext !== 32'hFFFFFFFF) begin
                    failures++; $display("FAIL addi_csext: got %h required ffffffff", c_sext);
                end
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [4:0] opc [0:9];
        logic [3:0] aop [0:9];
        logic       cuse [0:9];
        opc  = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd13, 5'd14};
        aop  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2, 4'd3};
        cuse = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            do_reset();
            ir = {opc[i], 27'h0} | 32'h00918000;
            for (int k = 0; k < 6; k++) begin
                @(negedge clock);
                run = (k == 0); mem_ready = 1'b1;
                #1;
                if (k == 4) begin
                    checks++;
                    if ({step, alu_op, c_out} !== {4'd4, aop[i], cuse[i]}) begin
                        failures++;
                        $display("FAIL alu_op_%0d: got %h required %h", opc[i], {step, alu_op, c_out}, {4'd4, aop[i], cuse[i]});
                    end
                end
            end
        end
    endtask

    task automatic test_nop_wait();
        logic [53:0] exp [0:5];
        logic        mr  [0:5];
        do_reset();
        ir = 32'hD0000000;
        exp = '{f0, mk(4'd1, M_READ, 16'h0, 16'h0, 4'd0), f1, f2,
                mk(4'd3, 14'h0, 16'h0, 16'h0, 4'd0), idle0};
        mr  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            run = (k == 0); mem_ready = mr[k];
            #1;
            checks++;
            if (obs !== exp[k]) begin
                failures++; $display("FAIL nop_c%0d: got %h required %h", k, obs, exp[k]);
            end
        end
    endtask

    task automatic test_ld();
        logic [53:0] exp [0:10];
        logic        mr  [0:10];
        do_reset();
        ir = 32'h02000020;
        exp = '{f0, f1, f2,
                mk(4'd3, M_BA_OUT | M_Y_IN, 16'h0, 16'h0, 4'd0),
                mk(4'd4, M_C_OUT | M_Z_IN, 16'h0, 16'h0, 4'd0),
                mk(4'd5, M_ZLO_OUT | M_MAR_IN, 16'h0, 16'h0, 4'd0),
                mk(4'd6, M_READ, 16'h0, 16'h0, 4'd0),
                mk(4'd6, M_READ, 16'h0, 16'h0, 4'd0),
                mk(4'd6, M_READ | M_MDR_IN, 16'h0, 16'h0, 4'd0),
                mk(4'd7, M_MDR_OUT, 16'h0010, 16'h0, 4'd0),
                idle0};
        mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            run = (k == 0); mem_ready = mr[k];
            #1;
            checks++;
            if (obs !== exp[k]) begin
                failures++; $display("FAIL ld_c%0d: got %h required %h", k, obs, exp[k]);
            end
            if (k == 4) begin
                checks++;
                if (c_sext !== 32'h00000020) begin
                    failures++; $display("FAIL ld_csext: got %h required 00000020", c_sext);
                end
            end
        end
    endtask

    task automatic test_st();
        logic [53:0] exp [0:9];
        logic        mr  [0:9];
        do_reset();
        ir = 32'h12B00004;
        exp = '{f0, f1, f2,
                mk(4'd3, M_Y_IN, 16'h0, 16'h0040, 4'd0),
                mk(4'd4, M_C_OUT | M_Z_IN, 16'h0, 16'h0, 4'd0),
                mk(4'd5, M_ZLO_OUT | M_MAR_IN, 16'h0, 16'h0, 4'd0),
                mk(4'd6, M_MDR_IN, 16'h0, 16'h0020, 4'd0),
                mk(4'd7, M_WRITE, 16'h0, 16'h0, 4'd0),
                mk(4'd7, M_WRITE, 16'h0, 16'h0, 4'd0),
                idle0};
        mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            run = (k == 0); mem_ready = mr[k];
            #1;
            checks++;
            if (obs !== exp[k]) begin
                failures++; $display("FAIL st_c%0d: got %h required %h", k, obs, exp[k]);
            end
        end
    endtask

    task automatic test_halt_illegal();
        logic [53:0] exp [0:4];
        logic [53:0] halt0;
        halt0 = mk(4'd8, 14'h0, 16'h0, 16'h0, 4'd0);
        exp = '{f0, f1, f2, mk(4'd3, 14'h0, 16'h0, 16'h0, 4'd0), halt0};
        do_reset();
        ir = 32'hD8000000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            run = (k == 0) || (k > 4); mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== exp[(k > 4) ? 4 : k]) begin
                failures++; $display("FAIL halt_c%0d: got %h required %h", k, obs, exp[(k > 4) ? 4 : k]);
            end
        end
        checks++;
        if ({halted, illegal} !== 2'b10) begin
            failures++; $display("FAIL halt_flags: got %b required 10", {halted, illegal});
        end
        do_reset();
        #1;
        checks++;
        if ({halted, illegal, step} !== 6'b000000) begin
            failures++; $display("FAIL halt_cleared: got %b required 000000", {halted, illegal, step});
        end
        ir = 32'hF8000000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            run = (k == 0); mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== exp[k]) begin
                failures++; $display("FAIL illegal_c%0d: got %h required %h", k, obs, exp[k]);
            end
        end
        checks++;
        if ({halted, illegal} !== 2'b11) begin
            failures++; $display("FAIL illegal_flags: got %b required 11", {halted, illegal});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ir = 32'h02000020;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            run = (k == 0); mem_ready = (k < 6);
        end
        #1;
        checks++;
        if (obs !== mk(4'd6, M_READ, 16'h0, 16'h0, 4'd0)) begin
            failures++; $display("FAIL midreset_t6: got %h required %h", obs, mk(4'd6, M_READ, 16'h0, 16'h0, 4'd0));
        end
        @(negedge clock);
        clear_n = 1'b0;
        #1;
        checks++;
        if (obs !== idle0) begin
            failures++; $display("FAIL midreset_async: got %h required %h", obs, idle0);
        end
        @(negedge clock);
        clear_n = 1'b1; run = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== f0) begin
            failures++; $display("FAIL midreset_t0: got %h required %h", obs, f0);
        end
        @(negedge clock);
        run = 1'b0;
        #1;
        checks++;
        if (obs !== f1) begin
            failures++; $display("FAIL midreset_t1: got %h required %h", obs, f1);
        end
    endtask

    initial begin
        f0    = mk(4'd0, M_PC_OUT | M_MAR_IN | M_INC_PC, 16'h0, 16'h0, 4'd0);
        f1    = mk(4'd1, M_READ | M_MDR_IN, 16'h0, 16'h0, 4'd0);
        f2    = mk(4'd2, M_MDR_OUT | M_IR_IN, 16'h0, 16'h0, 4'd0);
        idle0 = mk(4'd0, 14'h0, 16'h0, 16'h0, 4'd0);
        test_reset();
        test_add();
        test_addi();
        test_alu_ops();
        test_nop_wait();
        test_ld();
        test_st();
        test_halt_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
